// File: rtl/rs232_tx_core.sv
// rtl/rs232_tx_core.sv - RS-232 serial transmitter: start bit, 8 data bits LSB first, 1 or 2 stop bits
module rs232_tx_core #(
  parameter int CLKS_PER_BIT = 434,
  parameter int STOP_BITS    = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       drl,
  input  logic [7:0] din,
  output logic       load,
  output logic       tx,
  output logic       busy
);

  localparam int              CW        = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0]   BAUD_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic            STOP_LAST = 1'(STOP_BITS - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] baud_q, baud_d;
  logic [2:0]    idx_q, idx_d;
  logic          stop_q, stop_d;
  logic [7:0]    sh_q, sh_d;
  logic          tx_d, load_d, busy_d;
  logic          baud_wrap;

  assign baud_wrap = (baud_q == BAUD_LAST);

  // Next-state and next-output logic; every output is registered, so the
  // line level computed here appears on tx at the same edge the state changes.
  always_comb begin
    state_d = state_q;
    baud_d  = baud_q;
    idx_d   = idx_q;
    stop_d  = stop_q;
    sh_d    = sh_q;
    tx_d    = tx;
    busy_d  = busy;
    load_d  = 1'b0;

    case (state_q)
      IDLE: begin
        tx_d   = 1'b1;
        busy_d = 1'b0;
        if (drl) begin
          sh_d    = din;
          tx_d    = 1'b0;
          busy_d  = 1'b1;
          load_d  = 1'b1;
          baud_d  = '0;
          state_d = START;
        end
      end

      START: begin
        if (baud_wrap) begin
          baud_d  = '0;
          idx_d   = 3'd0;
          tx_d    = sh_q[0];
          state_d = DATA;
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end

      DATA: begin
        if (baud_wrap) begin
          baud_d = '0;
          if (idx_q == 3'd7) begin
            stop_d  = 1'b0;
            tx_d    = 1'b1;
            state_d = STOP;
          end else begin
            idx_d = idx_q + 3'd1;
            tx_d  = sh_q[idx_q + 3'd1];
          end
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end

      STOP: begin
        if (baud_wrap) begin
          baud_d = '0;
          if (stop_q == STOP_LAST) begin
            // Chain straight into the next frame when a byte is waiting,
            // so back-to-back bytes leave no idle-high gap on the line.
            if (drl) begin
              sh_d    = din;
              tx_d    = 1'b0;
              busy_d  = 1'b1;
              load_d  = 1'b1;
              state_d = START;
            end else begin
              tx_d    = 1'b1;
              busy_d  = 1'b0;
              state_d = IDLE;
            end
          end else begin
            stop_d = stop_q + 1'b1;
          end
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end

      default: begin
        tx_d    = 1'b1;
        busy_d  = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  // State and output registers; reset abandons any frame in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      baud_q  <= '0;
      idx_q   <= 3'd0;
      stop_q  <= 1'b0;
      sh_q    <= 8'h00;
      tx      <= 1'b1;
      load    <= 1'b0;
      busy    <= 1'b0;
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      idx_q   <= idx_d;
      stop_q  <= stop_d;
      sh_q    <= sh_d;
      tx      <= tx_d;
      load    <= load_d;
      busy    <= busy_d;
    end
  end

endmodule

// File: tb/tb_rs232_tx_core.sv
// tb/tb_rs232_tx_core.sv - scoreboard bench for rs232_tx_core (1 and 2 stop bits)
module tb_rs232_tx_core;

  localparam int CPB = 4;

  logic       clk = 1'b0;
  logic [1:0] rst_v = 2'b11;
  logic [1:0] drl_v = 2'b00;
  logic [7:0] din0 = 8'h00;
  logic [7:0] din1 = 8'h00;
  wire  [1:0] tx_v, load_v, busy_v;

  int checks = 0;
  int fails  = 0;

  logic [7:0] exp_q0[$];
  logic [7:0] exp_q1[$];

  always #5 clk = ~clk;

  rs232_tx_core #(.CLKS_PER_BIT(CPB), .STOP_BITS(1)) dut0 (
    .clk(clk), .rst(rst_v[0]), .drl(drl_v[0]), .din(din0),
    .load(load_v[0]), .tx(tx_v[0]), .busy(busy_v[0])
  );

  rs232_tx_core #(.CLKS_PER_BIT(CPB), .STOP_BITS(2)) dut1 (
    .clk(clk), .rst(rst_v[1]), .drl(drl_v[1]), .din(din1),
    .load(load_v[1]), .tx(tx_v[1]), .busy(busy_v[1])
  );

  // Expected line level of a frame carrying byte b, pos cycles after its load edge.
  function automatic logic level(input logic [7:0] b, input int pos);
    int bit_i;
    bit_i = pos / CPB;
    if (bit_i == 0) return 1'b0;
    if (bit_i <= 8) return b[bit_i - 1];
    return 1'b1;
  endfunction

  task automatic chk(input int k, input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s dut%0d: got %b expected %b at %0t", name, k, act, exp, $time);
    end
  endtask

  // Scoreboard monitor: follows frames from load pulses and checks every cycle.
  task automatic monitor(input int k, input int sb);
    int         len;
    bit         in_f;
    bit         armed;
    int         pos;
    logic [7:0] b;
    logic       r, d;
    len   = (9 + sb) * CPB;
    in_f  = 0;
    armed = 0;
    pos   = 0;
    b     = 8'h00;
    forever begin
      @(posedge clk);
      r = rst_v[k];
      d = drl_v[k];
      @(negedge clk);
      if (r) begin
        armed = 1;
        in_f  = 0;
        chk(k, "rst_tx", tx_v[k], 1'b1);
        chk(k, "rst_load", load_v[k], 1'b0);
        chk(k, "rst_busy", busy_v[k], 1'b0);
      end else if (armed) begin
        if (in_f) begin
          pos++;
          if (pos >= len) in_f = 0;
        end
        if (in_f) begin
          chk(k, "frame_tx", tx_v[k], level(b, pos));
          chk(k, "frame_busy", busy_v[k], 1'b1);
          chk(k, "frame_noload", load_v[k], 1'b0);
        end else begin
          chk(k, "load_when_drl", load_v[k], d);
          if (load_v[k] === 1'b1) begin
            checks++;
            if ((k == 0 ? exp_q0.size() : exp_q1.size()) == 0) begin
              fails++;
              $display("FAIL unexpected_load dut%0d: got load with empty queue at %0t", k, $time);
              b = 8'hxx;
            end else begin
              b = (k == 0) ? exp_q0.pop_front() : exp_q1.pop_front();
            end
            in_f = 1;
            pos  = 0;
            chk(k, "start_tx", tx_v[k], 1'b0);
            chk(k, "start_busy", busy_v[k], 1'b1);
          end else begin
            chk(k, "idle_tx", tx_v[k], 1'b1);
            chk(k, "idle_busy", busy_v[k], 1'b0);
          end
        end
      end
    end
  endtask

  initial monitor(0, 1);
  initial monitor(1, 2);

  task automatic wait_load(input int k, output bit ok);
    ok = 0;
    for (int i = 0; i < 200; i++) begin
      @(posedge clk);
      #1;
      if (load_v[k] === 1'b1) begin
        ok = 1;
        return;
      end
    end
  endtask

  // Present byte b with drl high, record it, and wait for the DUT to take it.
  task automatic issue(input int k, input logic [7:0] b);
    bit ok;
    if (k == 0) begin
      din0 = b;
      exp_q0.push_back(b);
    end else begin
      din1 = b;
      exp_q1.push_back(b);
    end
    drl_v[k] = 1'b1;
    wait_load(k, ok);
    if (!ok) begin
      checks++;
      fails++;
      $display("FAIL load_timeout dut%0d: got no load for byte %h within 200 cycles", k, b);
      if (k == 0) void'(exp_q0.pop_back());
      else        void'(exp_q1.pop_back());
      drl_v[k] = 1'b0;
    end
  endtask

  task automatic idle_wait(input int k, input int n);
    drl_v[k] = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pulse_rst(input int k);
    rst_v[k] = 1'b1;
    @(posedge clk);
    #1;
    rst_v[k] = 1'b0;
  endtask

  initial begin
    logic [7:0] b;
    int         mode;

    // Reset held three cycles with drl low, then idle.
    repeat (3) @(posedge clk);
    #1;
    rst_v = 2'b00;
    idle_wait(0, 6);

    // Single byte 0xA5 with a one-cycle drl pulse.
    issue(0, 8'hA5);
    idle_wait(0, 48);

    // Back-to-back 0xFF then 0x00 with drl held high.
    issue(0, 8'hFF);
    din0 = 8'h00;
    exp_q0.push_back(8'h00);
    begin
      bit ok;
      wait_load(0, ok);
      if (!ok) begin
        checks++;
        fails++;
        $display("FAIL b2b_load dut0: got no second load, expected one 40 cycles after the first");
        void'(exp_q0.pop_back());
      end
    end
    idle_wait(0, 48);

    // Reset landing in data bit 3 of 0x3C, then a clean 0x3C frame.
    issue(0, 8'h3C);
    drl_v[0] = 1'b0;
    repeat (16) @(posedge clk);
    #1;
    pulse_rst(0);
    idle_wait(0, 3);
    issue(0, 8'h3C);
    idle_wait(0, 48);

    // drl falls during the start bit of 0x81.
    issue(0, 8'h81);
    repeat (2) @(posedge clk);
    #1;
    idle_wait(0, 48);

    // Randomized traffic: single shots, back-to-back runs and stray resets.
    for (int n = 0; n < 24; n++) begin
      b    = 8'($urandom);
      mode = int'($urandom_range(0, 2));
      issue(0, b);
      if (mode == 0) begin
        idle_wait(0, int'($urandom_range(0, 50)));
      end else if (mode == 2) begin
        drl_v[0] = 1'b0;
        repeat (int'($urandom_range(0, 45))) @(posedge clk);
        #1;
        pulse_rst(0);
      end
    end
    idle_wait(0, 50);

    // Two stop bits: 0x00 then a few random bytes, one pair back-to-back.
    issue(1, 8'h00);
    idle_wait(1, 50);
    for (int n = 0; n < 4; n++) begin
      issue(1, 8'($urandom));
      if (n != 1) idle_wait(1, int'($urandom_range(0, 10)));
    end
    idle_wait(1, 60);

    checks++;
    if (exp_q0.size() != 0 || exp_q1.size() != 0) begin
      fails++;
      $display("FAIL queues_drained: got %0d/%0d bytes never sent, expected 0/0", exp_q0.size(), exp_q1.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
